// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Enable FETCH_MISALIGN_CHECK_EN to add the HALT state.
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    FULL,
    DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
    , HALT
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP_INST           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP            = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: imem req/gnt/rvalid, redirect and decode slot.
// FETCH_MISALIGN_CHECK_EN adds o_fetch_misalign.
interface fetch_if;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_id_ready;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic [31:0] o_inst_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        o_fetch_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
    output o_fetch_misalign,
`endif
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_gnt,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_id_ready,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc,
    output o_inst_pc_plus4
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
    input  o_fetch_misalign,
`endif
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_gnt,
    output i_imem_rvalid,
    output i_imem_rdata,
    output i_redirect,
    output i_redirect_pc,
    output i_id_ready,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc,
    input  o_inst_pc_plus4
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, one decode slot.
// FETCH_MISALIGN_CHECK_EN traps misaligned redirects into HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  fetch_state_e state_q, state_d;
  fetch_state_e redir_ns;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  infl_q, infl_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         valid_q, valid_d;
  logic [31:0]  tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic         mis_q, mis_d;
  logic         pend_q, pend_d;
  logic         misaligned;

  assign tgt        = bus.i_redirect_pc;
  assign misaligned = |bus.i_redirect_pc[1:0];
`else
  assign tgt = {bus.i_redirect_pc[31:2], 2'b00};
`endif

  // Where a redirect lands: DRAIN whenever a response is still owed.
  always_comb begin
    redir_ns = REQ;
    unique case (state_q)
      REQ:     redir_ns = bus.i_imem_gnt ? DRAIN : REQ;
      WAIT:    redir_ns = bus.i_imem_rvalid ? REQ : DRAIN;
      FULL:    redir_ns = REQ;
      DRAIN:   redir_ns = bus.i_imem_rvalid ? REQ : DRAIN;
`ifdef FETCH_MISALIGN_CHECK_EN
      HALT:    redir_ns = (pend_q && !bus.i_imem_rvalid) ? DRAIN : REQ;
`endif
      default: redir_ns = REQ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    infl_d  = infl_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d   = mis_q;
    pend_d  = pend_q;
`endif
    if (bus.i_redirect) begin
      pc_d    = tgt;
      valid_d = 1'b0;
      state_d = redir_ns;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d   = misaligned;
      pend_d  = 1'b0;
      if (misaligned) begin
        state_d = HALT;
        pend_d  = (redir_ns == DRAIN);
      end
`endif
    end else begin
      unique case (state_q)
        REQ: begin
          if (bus.i_imem_gnt) begin
            infl_d  = pc_q;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (bus.i_imem_rvalid) begin
            inst_d  = bus.i_imem_rdata;
            ipc_d   = infl_q;
            valid_d = 1'b1;
            pc_d    = infl_q + PC_STEP;
            state_d = FULL;
          end
        end
        FULL: begin
          if (valid_q && bus.i_id_ready) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
        DRAIN: begin
          if (bus.i_imem_rvalid) state_d = REQ;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        HALT: begin
          if (bus.i_imem_rvalid) pend_d = 1'b0;
        end
`endif
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_ADDR;
      infl_q  <= RESET_ADDR;
      inst_q  <= NOP_INST;
      ipc_q   <= 32'h0;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.o_imem_req      = (state_q == REQ) && !rst;
  assign bus.o_imem_addr     = pc_q;
  assign bus.o_inst_valid    = valid_q;
  assign bus.o_inst          = inst_q;
  assign bus.o_inst_pc       = ipc_q;
  assign bus.o_inst_pc_plus4 = ipc_q + PC_STEP;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.o_fetch_misalign = mis_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table with an auto 1-cycle memory,
// then hand-driven sequences for hold, drain, async reset and misalign.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory model: auto mode grants at once and answers next cycle
  logic        auto_q;
  logic        man_gnt, man_rv;
  logic [31:0] man_rdata;
  logic        rv_a;
  logic [31:0] rd_a;

  always @(posedge clk) begin
    rv_a <= bus.o_imem_req & bus.i_imem_gnt;
    rd_a <= {8'hA5, bus.o_imem_addr[23:0]};
  end

  assign bus.i_imem_gnt    = auto_q ? bus.o_imem_req : man_gnt;
  assign bus.i_imem_rvalid = auto_q ? rv_a : man_rv;
  assign bus.i_imem_rdata  = auto_q ? rd_a : man_rdata;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic rd, logic [31:0] rpc, logic rdy,
                              logic ev, logic [31:0] epc,
                              logic ereq, logic [31:0] eaddr);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.req",   {31'b0, bus.o_imem_req},   32'd0);
    chk("rst.valid", {31'b0, bus.o_inst_valid}, 32'd0);
    chk("rst.inst",  bus.o_inst,                32'h0000_0013);
    chk("rst.pc",    bus.o_inst_pc,             32'h0);
    chk("rst.pc4",   bus.o_inst_pc_plus4,       32'h4);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    auto_q = 1'b1;
    man_gnt = 1'b0; man_rv = 1'b0; man_rdata = 32'h0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_id_ready = 1'b1;

    //           rd  rpc           rdy ev  epc           req addr
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h4));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 32'h4,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h8));
    tbl.push_back(mk(1, 32'h100,      1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h100));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h104));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 1, 0, 32'h0,       0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 32'h40,       1, 1, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h40));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 32'h40,       0, 32'h0));
    tbl.push_back(mk(1, 32'h80,       1, 0, 32'h0,        1, 32'h44));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        1, 32'h80));
    tbl.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 32'h0,        1, 1, 32'h80,       0, 32'h0));

    do_reset();
    foreach (tbl[i]) begin
      bus.i_redirect    = tbl[i].rd;
      bus.i_redirect_pc = tbl[i].rpc;
      bus.i_id_ready    = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d.valid", i), {31'b0, bus.o_inst_valid},
          {31'b0, tbl[i].ev});
      chk($sformatf("v%0d.req", i), {31'b0, bus.o_imem_req},
          {31'b0, tbl[i].ereq});
      if (tbl[i].ereq)
        chk($sformatf("v%0d.addr", i), bus.o_imem_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d.pc", i), bus.o_inst_pc, tbl[i].epc);
        chk($sformatf("v%0d.pc4", i), bus.o_inst_pc_plus4,
            tbl[i].epc + 32'd4);
        chk($sformatf("v%0d.inst", i), bus.o_inst,
            {8'hA5, tbl[i].epc[23:0]});
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_redirect = 1'b0;
    bus.i_id_ready = 1'b1;

    // hand-driven memory
    auto_q = 1'b0;
    do_reset();
    #1 chk("h.req0", {31'b0, bus.o_imem_req}, 32'd1);
    chk("h.addr0", bus.o_imem_addr, 32'h0);
    @(negedge clk);
    #1 chk("h.hold", bus.o_imem_addr, 32'h0);
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h300;
    #1 chk("h.hold2", bus.o_imem_addr, 32'h0);
    @(negedge clk);
    bus.i_redirect = 1'b0;
    #1 chk("h.newaddr", bus.o_imem_addr, 32'h300);
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h400;
    #1 chk("h.wait.req", {31'b0, bus.o_imem_req}, 32'd0);
    @(negedge clk);
    bus.i_redirect = 1'b0;
    man_rv = 1'b1; man_rdata = 32'hDEAD_BEEF;
    #1 chk("h.drain.valid", {31'b0, bus.o_inst_valid}, 32'd0);
    @(negedge clk);
    man_rv = 1'b0;
    #1 chk("h.drop.valid", {31'b0, bus.o_inst_valid}, 32'd0);
    chk("h.drop.req", {31'b0, bus.o_imem_req}, 32'd1);
    chk("h.drop.addr", bus.o_imem_addr, 32'h400);
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    man_rv = 1'b1; man_rdata = 32'h1234_5678;
    @(negedge clk);
    man_rv = 1'b1; man_rdata = 32'hBADB_AD00;
    bus.i_id_ready = 1'b0;
    #1 chk("h.cap.valid", {31'b0, bus.o_inst_valid}, 32'd1);
    chk("h.cap.inst", bus.o_inst, 32'h1234_5678);
    chk("h.cap.pc", bus.o_inst_pc, 32'h400);
    chk("h.cap.pc4", bus.o_inst_pc_plus4, 32'h404);
    @(negedge clk);
    man_rv = 1'b0;
    bus.i_id_ready = 1'b1;
    #1 chk("h.stray.inst", bus.o_inst, 32'h1234_5678);
    chk("h.stray.valid", {31'b0, bus.o_inst_valid}, 32'd1);
    @(negedge clk);
    #1 chk("h.next.valid", {31'b0, bus.o_inst_valid}, 32'd0);
    chk("h.next.addr", bus.o_imem_addr, 32'h404);
    man_gnt = 1'b1;
    @(negedge clk);
    man_gnt = 1'b0;
    #1 chk("h.w.req", {31'b0, bus.o_imem_req}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("a.req", {31'b0, bus.o_imem_req}, 32'd0);
    chk("a.valid", {31'b0, bus.o_inst_valid}, 32'd0);
    chk("a.inst", bus.o_inst, 32'h0000_0013);
    chk("a.pc", bus.o_inst_pc, 32'h0);
    chk("a.pc4", bus.o_inst_pc_plus4, 32'h4);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("a.refetch.req", {31'b0, bus.o_imem_req}, 32'd1);
    chk("a.refetch.addr", bus.o_imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    chk("m.flag0", {31'b0, bus.o_fetch_misalign}, 32'd0);
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h102;
    @(negedge clk);
    bus.i_redirect = 1'b0;
    #1 chk("m.flag1", {31'b0, bus.o_fetch_misalign}, 32'd1);
    chk("m.req0", {31'b0, bus.o_imem_req}, 32'd0);
    @(negedge clk);
    #1 chk("m.req1", {31'b0, bus.o_imem_req}, 32'd0);
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h200;
    @(negedge clk);
    bus.i_redirect = 1'b0;
    #1 chk("m.clr", {31'b0, bus.o_fetch_misalign}, 32'd0);
    chk("m.req2", {31'b0, bus.o_imem_req}, 32'd1);
    chk("m.addr", bus.o_imem_addr, 32'h200);
`else
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h123;
    @(negedge clk);
    bus.i_redirect = 1'b0;
    #1 chk("m.req", {31'b0, bus.o_imem_req}, 32'd1);
    chk("m.align", bus.o_imem_addr, 32'h120);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
